// File: rtl/mux_pkg.sv
// Shared definitions for blocks that drive a mux4x1.
//   state_t   : scan sequencer FSM states
//   NUM_CH    : number of mux4x1 data channels
//   ch_to_sel : channel index -> mux4x1 select encoding
package mux_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    OUT    = 2'd3
  } state_t;

  localparam int NUM_CH = 4;

  // mux4x1 picks channel k when s[0]=k[1] and s[1]=k[0], so the two
  // channel bits are swapped on the way into the select port.
  function automatic logic [1:0] ch_to_sel(input logic [1:0] ch);
    return {ch[0], ch[1]};
  endfunction

endpackage

// File: rtl/mux4x1.sv
// Four-to-one single-bit multiplexer.
//   a : data channels, a[k] is channel k
//   s : select, channel k chosen when s[0]=k[1], s[1]=k[0]
//   f : selected channel
module mux4x1 (
  input  logic [3:0] a,
  input  logic [1:0] s,
  output logic       f
);

  assign f = a[{s[0], s[1]}];

endmodule

// File: rtl/settle_timer.sv
// Loadable down-counter with a zero flag, used to hold each mux channel
// for a fixed number of cycles before sampling.
//   clk, rst_n : clock, synchronous active-low reset (count -> 0)
//   load       : load load_val (has priority over dec)
//   load_val   : value to load
//   dec        : decrement by one; saturates at zero
//   zero       : count == 0
module settle_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mux_scan_sequencer.sv
// Scan sequencer placed in front of a mux4x1: walks channels 0..3, holds
// each one for SETTLE_CYCLES cycles, samples mux_f once, and presents the
// four samples as a 4-bit word.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : scan request, honoured only in IDLE
//   continuous : restart a scan automatically after each accepted word
//   mux_f      : mux4x1 output
//   s          : mux4x1 select, derived only from the channel register
//   busy       : state != IDLE
//   out_data   : sampled word, bit k = channel k
//   out_valid  : word available
//   out_ready  : consumer ready
//   state_dbg  : current FSM state
//
// Output handshake: a word transfers on a rising edge where
// out_valid && out_ready. While out_valid is high and out_ready is low,
// out_data and s are held unchanged; out_valid never drops without a
// transfer except through reset.
module mux_scan_sequencer
  import mux_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       continuous,
  input  logic       mux_f,
  output logic [1:0] s,
  output logic       busy,
  output logic [3:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output state_t     state_dbg
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  // The load happens on the edge entering SETTLE, so loading N-1 and
  // leaving at zero gives exactly N SETTLE cycles.
  localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [1:0] LAST_CH = 2'(NUM_CH - 1);

  state_t      state_q, state_d;
  logic [1:0]  ch_q, ch_d;
  logic [2:0]  shadow_q, shadow_d;
  logic [3:0]  out_data_q, out_data_d;
  logic        timer_load, timer_dec, timer_zero;

  settle_timer #(
    .W(CW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (RELOAD),
    .dec      (timer_dec),
    .zero     (timer_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ch_q       <= 2'd0;
      shadow_q   <= 3'd0;
      out_data_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      shadow_q   <= shadow_d;
      out_data_q <= out_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    shadow_d   = shadow_q;
    out_data_d = out_data_q;
    timer_load = 1'b0;
    timer_dec  = 1'b0;

    case (state_q)
      IDLE: begin
        ch_d = 2'd0;
        if (start) begin
          timer_load = 1'b1;
          state_d    = SETTLE;
        end
      end

      SETTLE: begin
        if (timer_zero) begin
          state_d = SAMPLE;
        end else begin
          timer_dec = 1'b1;
        end
      end

      SAMPLE: begin
        case (ch_q)
          2'd0:    shadow_d[0] = mux_f;
          2'd1:    shadow_d[1] = mux_f;
          2'd2:    shadow_d[2] = mux_f;
          default: ;
        endcase
        if (ch_q == LAST_CH) begin
          // Last channel goes straight into the word, no shadow needed.
          out_data_d = {mux_f, shadow_q};
          state_d    = OUT;
        end else begin
          ch_d       = ch_q + 2'd1;
          timer_load = 1'b1;
          state_d    = SETTLE;
        end
      end

      OUT: begin
        if (out_ready) begin
          // Channel returns to 0 on either exit so s reads 00 in IDLE.
          ch_d = 2'd0;
          if (continuous) begin
            timer_load = 1'b1;
            state_d    = SETTLE;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign s         = ch_to_sel(ch_q);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == OUT);
  assign out_data  = out_data_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
module tb_mux_scan_sequencer;
  import mux_pkg::*;

  localparam int SC  = 2;
  localparam int PER = SC + 1;        // cycles spent on one channel
  localparam int LAT = 1 + 4 * PER;   // first out_valid cycle, start cycle = 0

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst_n, start, continuous, out_ready;
  logic       mux_f, busy, out_valid;
  logic [1:0] s;
  logic [3:0] out_data, a;
  state_t     state_dbg;

  always #5 clk = ~clk;

  mux_scan_sequencer #(
    .SETTLE_CYCLES(SC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .continuous (continuous),
    .mux_f      (mux_f),
    .s          (s),
    .busy       (busy),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .state_dbg  (state_dbg)
  );

  mux4x1 u_mux (
    .a (a),
    .s (s),
    .f (mux_f)
  );

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         failures = 0;
  logic [3:0] exp_q[$];
  logic [1:0] sel_tab[4];

  typedef struct {
    logic [3:0] a;
    int         ready_at;   // cycle in which out_ready is first raised
    logic [3:0] exp_word;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // One clock: observe the handshake at negedge (values the edge will
  // sample), then move to 1 time unit after the rising edge.
  task automatic step();
    @(negedge clk);
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word got=%0h exp=none", out_data);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        check("word", {28'd0, out_data}, {28'd0, e});
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_vector(input vec_t v);
    logic [1:0] es;
    logic       ev;
    a          = v.a;
    out_ready  = 1'b0;
    continuous = 1'b0;
    exp_q.push_back(v.exp_word);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= v.ready_at + 1; c++) begin
      out_ready = (c >= v.ready_at);
      if (c < LAT)             es = sel_tab[(c - 1) / PER];
      else if (c <= v.ready_at) es = 2'b11;
      else                     es = 2'b00;
      ev = (c >= LAT) && (c <= v.ready_at);
      check($sformatf("s_a%0h_c%0d", v.a, c), {30'd0, s}, {30'd0, es});
      check($sformatf("valid_a%0h_c%0d", v.a, c), {31'd0, out_valid}, {31'd0, ev});
      check($sformatf("busy_a%0h_c%0d", v.a, c), {31'd0, busy}, {31'd0, (c <= v.ready_at)});
      if (ev) check($sformatf("data_a%0h_c%0d", v.a, c), {28'd0, out_data}, {28'd0, v.exp_word});
      step();
    end
    out_ready = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    int n_words, w1, w2;
    sel_tab[0] = 2'b00; sel_tab[1] = 2'b10; sel_tab[2] = 2'b01; sel_tab[3] = 2'b11;
    vecs[0] = '{a: 4'b1010, ready_at: LAT,      exp_word: 4'b1010};
    vecs[1] = '{a: 4'b0110, ready_at: 30,       exp_word: 4'b0110};
    vecs[2] = '{a: 4'b0000, ready_at: LAT,      exp_word: 4'b0000};
    vecs[3] = '{a: 4'b1111, ready_at: LAT + 2,  exp_word: 4'b1111};
    vecs[4] = '{a: 4'b0001, ready_at: LAT,      exp_word: 4'b0001};
    vecs[5] = '{a: 4'b1000, ready_at: LAT + 1,  exp_word: 4'b1000};

    rst_n = 1'b0; start = 1'b0; continuous = 1'b0; out_ready = 1'b0; a = 4'b0000;

    // Reset / idle
    repeat (3) step();
    rst_n = 1'b1;
    check("reset_state", {30'd0, state_dbg}, {30'd0, IDLE});
    for (int c = 0; c < 20; c++) begin
      check($sformatf("idle_s_c%0d", c), {30'd0, s}, 32'd0);
      check($sformatf("idle_valid_c%0d", c), {31'd0, out_valid}, 32'd0);
      check($sformatf("idle_busy_c%0d", c), {31'd0, busy}, 32'd0);
      check($sformatf("idle_data_c%0d", c), {28'd0, out_data}, 32'd0);
      step();
    end

    // Table-driven single scans, including backpressure
    for (int i = 0; i < 6; i++) run_vector(vecs[i]);

    // Continuous mode: two words LAT cycles apart, busy held throughout
    a = 4'b0001; continuous = 1'b1; out_ready = 1'b1;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b1000);
    n_words = 0; w1 = 0; w2 = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 2 * LAT; c++) begin
      if (c == LAT + 1) a = 4'b1000;
      if (c == 2 * LAT) continuous = 1'b0;
      check($sformatf("cont_busy_c%0d", c), {31'd0, busy}, 32'd1);
      if (out_valid) begin
        n_words++;
        if (n_words == 1) w1 = c; else w2 = c;
      end
      step();
    end
    check("cont_words", n_words, 2);
    check("cont_w1_cycle", w1, LAT);
    check("cont_w2_cycle", w2, 2 * LAT);
    check("cont_idle_after", {31'd0, busy}, 32'd0);
    out_ready = 1'b0;

    // Ignored start and settle-time glitch on channel 1
    a = 4'b0101; out_ready = 1'b1;
    exp_q.push_back(4'b0101);
    n_words = 0; w1 = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= LAT + 20; c++) begin
      if (c == PER + 1) a = 4'b0111;       // ch1 SETTLE begins
      if (c == 2 * PER) a = 4'b0101;       // restored for ch1 SAMPLE
      start = (c == 5);
      if (out_valid) begin
        n_words++;
        w1 = c;
      end
      step();
    end
    start = 1'b0;
    check("glitch_words", n_words, 1);
    check("glitch_cycle", w1, LAT);
    out_ready = 1'b0;

    // Reset mid-scan
    a = 4'b1111; out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 7; c++) step();
    check("midscan_busy", {31'd0, busy}, 32'd1);
    check("midscan_s", {30'd0, s}, 32'b01);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("abort_state", {30'd0, state_dbg}, {30'd0, IDLE});
    check("abort_s", {30'd0, s}, 32'd0);
    n_words = 0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid || busy) n_words++;
      step();
    end
    check("abort_quiet", n_words, 0);
    out_ready = 1'b0;
    run_vector('{a: 4'b1001, ready_at: LAT, exp_word: 4'b1001});

    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
